// File: rtl/mario_motion_ctrl_if.sv
// Frame-rate motion bundle between the player-input/collision side and the sprite position logic.
// No backpressure: the consumer must accept each motion_valid pulse.
interface mario_motion_ctrl_if;
  logic               frame_tick;
  logic [31:0]        keycode;
  logic               on_ground;
  logic               hit_ceiling;
  logic signed [9:0]  x_motion;
  logic signed [9:0]  y_motion;
  logic               motion_valid;
  logic [1:0]         state;
  logic               jump_active;

  modport master (
    output frame_tick, keycode, on_ground, hit_ceiling,
    input  x_motion, y_motion, motion_valid, state, jump_active
  );

  modport slave (
    input  frame_tick, keycode, on_ground, hit_ceiling,
    output x_motion, y_motion, motion_valid, state, jump_active
  );
endinterface

// File: rtl/mario_motion_ctrl.sv
// Player motion controller: key decode, ground/rise/fall jump FSM with gravity, per-frame X/Y step.
// Outputs update on the edge sampling frame_tick (one-cycle latency); no backpressure.
module mario_motion_ctrl #(
  parameter int JUMP_V0    = 8,
  parameter int GRAVITY    = 1,
  parameter int GRAV_DIV   = 2,
  parameter int MAX_FALL   = 6,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_CUT   = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  mario_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10
  } state_t;

  localparam int CW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic signed [9:0] TAKEOFF_V = 10'(-JUMP_V0);
  localparam logic signed [9:0] CUT_V     = 10'(-JUMP_CUT);
  localparam logic signed [9:0] GRAV_V    = 10'(GRAVITY);
  localparam logic signed [9:0] FALL_MAX  = 10'(MAX_FALL);
  localparam logic signed [9:0] WALK_V    = 10'(WALK_SPEED);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(GRAV_DIV - 1);

  state_t            st;
  logic signed [9:0] vy;
  logic [CW-1:0]     grav_cnt;
  logic              jump_armed;

  logic              key_w, key_a, key_d;
  logic signed [9:0] x_step;
  logic              grav_wrap;
  logic signed [9:0] grav_vy;
  logic signed [9:0] grav_vy_sat;
  logic [CW-1:0]     grav_cnt_nx;

  always_comb begin
    key_w = 1'b0;
    key_a = 1'b0;
    key_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.keycode[8*i +: 8] == 8'h1A) key_w = 1'b1;
      if (bus.keycode[8*i +: 8] == 8'h04) key_a = 1'b1;
      if (bus.keycode[8*i +: 8] == 8'h07) key_d = 1'b1;
    end
  end

  always_comb begin
    case ({key_a, key_d})
      2'b10:   x_step = -WALK_V;
      2'b01:   x_step = WALK_V;
      default: x_step = '0;
    endcase
  end

  // Gravity step shared by RISE and FALL; the FALL path uses the saturated value.
  always_comb begin
    grav_wrap   = (grav_cnt == CNT_LAST);
    grav_vy     = grav_wrap ? (vy + GRAV_V) : vy;
    grav_cnt_nx = grav_wrap ? '0 : (grav_cnt + 1'b1);
    grav_vy_sat = (grav_vy > FALL_MAX) ? FALL_MAX : grav_vy;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st               <= GROUND;
      vy               <= '0;
      grav_cnt         <= '0;
      jump_armed       <= 1'b1;
      bus.x_motion     <= '0;
      bus.y_motion     <= '0;
      bus.motion_valid <= 1'b0;
      bus.state        <= GROUND;
      bus.jump_active  <= 1'b0;
    end else begin
      bus.motion_valid <= bus.frame_tick;
      if (bus.frame_tick) begin
        bus.x_motion <= x_step;
        if (!key_w) jump_armed <= 1'b1;
        case (st)
          GROUND: begin
            if (bus.on_ground && key_w && jump_armed) begin
              st <= RISE; vy <= TAKEOFF_V; grav_cnt <= '0; jump_armed <= 1'b0;
              bus.y_motion <= TAKEOFF_V; bus.state <= RISE; bus.jump_active <= 1'b1;
            end else if (!bus.on_ground) begin
              st <= FALL; vy <= '0; grav_cnt <= '0;
              bus.y_motion <= '0; bus.state <= FALL; bus.jump_active <= 1'b1;
            end else begin
              vy <= '0; bus.y_motion <= '0;
            end
          end
          RISE: begin
            if (bus.hit_ceiling) begin
              st <= FALL; vy <= '0; grav_cnt <= '0;
              bus.y_motion <= '0; bus.state <= FALL;
            end else if (!key_w && (vy < CUT_V)) begin
              // Early release shortens the jump; the gravity phase is left untouched.
              vy <= CUT_V; bus.y_motion <= CUT_V;
            end else begin
              vy <= grav_vy; grav_cnt <= grav_cnt_nx; bus.y_motion <= grav_vy;
              if (grav_vy >= 10'sd0) begin
                st <= FALL; bus.state <= FALL;
              end
            end
          end
          FALL: begin
            if (bus.on_ground) begin
              st <= GROUND; vy <= '0;
              bus.y_motion <= '0; bus.state <= GROUND; bus.jump_active <= 1'b0;
            end else begin
              vy <= grav_vy_sat; grav_cnt <= grav_cnt_nx; bus.y_motion <= grav_vy_sat;
            end
          end
          default: begin
            st <= GROUND; vy <= '0; grav_cnt <= '0;
            bus.y_motion <= '0; bus.state <= GROUND; bus.jump_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed, table-driven bench for mario_motion_ctrl with default parameters.
module tb_mario_motion_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  mario_motion_ctrl_if bus();

  mario_motion_ctrl dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] kc;
    logic        og;
    logic        hc;
    int          ex;
    int          ey;
    int          est;
  } vec_t;

  vec_t ta[6];
  vec_t tb[16];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input logic [31:0] kc, input logic og, input logic hc);
    @(negedge clk);
    bus.keycode     = kc;
    bus.on_ground   = og;
    bus.hit_ceiling = hc;
    bus.frame_tick  = 1'b1;
    @(negedge clk);
    bus.frame_tick  = 1'b0;
  endtask

  task automatic check_out(input string tag, input int ex, input int ey, input int est);
    chk({tag, ".x"},     int'(bus.x_motion), ex);
    chk({tag, ".y"},     int'(bus.y_motion), ey);
    chk({tag, ".state"}, int'(bus.state), est);
    chk({tag, ".valid"}, int'(bus.motion_valid), 1);
    chk({tag, ".jact"},  int'(bus.jump_active), (est != 0) ? 1 : 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    tick(v.kc, v.og, v.hc);
    check_out(tag, v.ex, v.ey, v.est);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ey;
    n_chk  = 0;
    n_pass = 0;

    // takeoff and first rise ticks, gravity every second frame
    ta[0] = '{32'h0000_0007, 1'b1, 1'b0,  2,  0, 0};
    ta[1] = '{32'h0000_001A, 1'b1, 1'b0,  0, -8, 1};
    ta[2] = '{32'h0000_001A, 1'b0, 1'b0,  0, -8, 1};
    ta[3] = '{32'h0000_001A, 1'b0, 1'b0,  0, -7, 1};
    ta[4] = '{32'h0000_041A, 1'b0, 1'b0, -2, -7, 1};
    ta[5] = '{32'h0000_071A, 1'b0, 1'b0,  2, -6, 1};

    // landing, re-arm, jump cut, ceiling, ledge, A/D combos
    tb[0]  = '{32'h0000_001A, 1'b1, 1'b0,  0,  0, 0};
    tb[1]  = '{32'h0000_001A, 1'b1, 1'b0,  0,  0, 0};
    tb[2]  = '{32'h0000_0000, 1'b1, 1'b0,  0,  0, 0};
    tb[3]  = '{32'h0000_001A, 1'b1, 1'b0,  0, -8, 1};
    tb[4]  = '{32'h0000_001A, 1'b0, 1'b0,  0, -8, 1};
    tb[5]  = '{32'h0000_001A, 1'b0, 1'b0,  0, -7, 1};
    tb[6]  = '{32'h0000_0000, 1'b0, 1'b0,  0, -2, 1};
    tb[7]  = '{32'h0000_0000, 1'b0, 1'b0,  0, -2, 1};
    tb[8]  = '{32'h0000_0000, 1'b1, 1'b1,  0,  0, 2};
    tb[9]  = '{32'h0000_0000, 1'b1, 1'b0,  0,  0, 0};
    tb[10] = '{32'h0000_0704, 1'b1, 1'b0,  0,  0, 0};
    tb[11] = '{32'h0000_0004, 1'b1, 1'b0, -2,  0, 0};
    tb[12] = '{32'h0000_0000, 1'b0, 1'b0,  0,  0, 2};
    tb[13] = '{32'h0000_0000, 1'b0, 1'b0,  0,  0, 2};
    tb[14] = '{32'h0000_0000, 1'b1, 1'b0,  0,  0, 0};
    tb[15] = '{32'h1A00_0000, 1'b1, 1'b0,  0, -8, 1};

    rst_n           = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.keycode     = '0;
    bus.on_ground   = 1'b1;
    bus.hit_ceiling = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.x",     int'(bus.x_motion), 0);
    chk("rst.y",     int'(bus.y_motion), 0);
    chk("rst.state", int'(bus.state), 0);
    chk("rst.valid", int'(bus.motion_valid), 0);
    chk("rst.jact",  int'(bus.jump_active), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec($sformatf("ta%0d", i), ta[i]);

    // no tick: everything holds, valid drops
    @(negedge clk);
    bus.keycode = 32'h0; bus.on_ground = 1'b1; bus.hit_ceiling = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold.valid", int'(bus.motion_valid), 0);
    chk("hold.y",     int'(bus.y_motion), -6);
    chk("hold.x",     int'(bus.x_motion), 2);
    chk("hold.state", int'(bus.state), 1);

    // rise ticks 5..16 after takeoff, W held
    for (int k = 5; k <= 16; k++) begin
      tick(32'h0000_001A, 1'b0, 1'b0);
      check_out($sformatf("rise%0d", k), 0, -8 + k / 2, (k == 16) ? 2 : 1);
    end

    // fall toward terminal speed
    for (int j = 1; j <= 20; j++) begin
      ey = (j / 2 > 6) ? 6 : j / 2;
      tick(32'h0000_001A, 1'b0, 1'b0);
      check_out($sformatf("fall%0d", j), 0, ey, 2);
    end

    for (int i = 0; i < 16; i++) run_vec($sformatf("tb%0d", i), tb[i]);

    // asynchronous reset mid-rise, sampled before the next clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("arst.x",     int'(bus.x_motion), 0);
    chk("arst.y",     int'(bus.y_motion), 0);
    chk("arst.state", int'(bus.state), 0);
    chk("arst.valid", int'(bus.motion_valid), 0);
    chk("arst.jact",  int'(bus.jump_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick(32'h0000_001A, 1'b1, 1'b0);
    check_out("post_rst", 0, -8, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
